// File: rtl/tl_ad_buffer.sv
// TileLink-UL A/D channel buffer: one independently sized circular FIFO per channel,
// each with optional empty-bypass (flow) and full-pass-through (pipe) behaviour.

module tl_ad_buffer_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2,
    parameter bit          FLOW  = 1'b0,
    parameter bit          PIPE  = 1'b0,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bits,
    output logic [CW-1:0]    count
);
    localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             maybe_full;
    logic             ptr_match;
    logic             empty;
    logic             full;
    logic             bypass;
    logic             do_enq;
    logic             do_deq;

    always_comb begin
        ptr_match = (wptr == rptr);
        empty     = ptr_match && !maybe_full;
        full      = ptr_match && maybe_full;
        in_ready  = !reset && (!full || (PIPE && out_ready));
        out_valid = !reset && (!empty || (FLOW && in_valid));
        bypass    = FLOW && empty;
        out_bits  = bypass ? in_bits : mem[rptr];
        // A bypassed beat that is taken immediately never touches storage.
        do_enq    = in_valid && in_ready && !(bypass && out_ready);
        do_deq    = out_valid && out_ready && !empty;
        if (full)
            count = CW'(DEPTH);
        else if (wptr >= rptr)
            count = CW'(wptr) - CW'(rptr);
        else
            count = CW'(DEPTH) + CW'(wptr) - CW'(rptr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (do_enq)
                wptr <= (wptr == LAST) ? '0 : wptr + PW'(1);
            if (do_deq)
                rptr <= (rptr == LAST) ? '0 : rptr + PW'(1);
            if (do_enq != do_deq)
                maybe_full <= do_enq;
        end
    end

    always_ff @(posedge clock) begin
        if (do_enq)
            mem[wptr] <= in_bits;
    end
endmodule

module tl_ad_buffer #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SRC_W   = 7,
    parameter int unsigned SIZE_W  = 4,
    parameter int unsigned A_DEPTH = 2,
    parameter int unsigned D_DEPTH = 2,
    parameter int unsigned A_FLOW  = 0,
    parameter int unsigned D_FLOW  = 0,
    parameter int unsigned A_PIPE  = 0,
    parameter int unsigned D_PIPE  = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           a_in_valid,
    output logic                           a_in_ready,
    input  logic [2:0]                     a_in_opcode,
    input  logic [2:0]                     a_in_param,
    input  logic [SIZE_W-1:0]              a_in_size,
    input  logic [SRC_W-1:0]               a_in_source,
    input  logic [ADDR_W-1:0]              a_in_address,
    input  logic [DATA_W/8-1:0]            a_in_mask,
    input  logic [DATA_W-1:0]              a_in_data,
    input  logic                           a_in_corrupt,
    output logic                           a_out_valid,
    input  logic                           a_out_ready,
    output logic [2:0]                     a_out_opcode,
    output logic [2:0]                     a_out_param,
    output logic [SIZE_W-1:0]              a_out_size,
    output logic [SRC_W-1:0]               a_out_source,
    output logic [ADDR_W-1:0]              a_out_address,
    output logic [DATA_W/8-1:0]            a_out_mask,
    output logic [DATA_W-1:0]              a_out_data,
    output logic                           a_out_corrupt,
    input  logic                           d_in_valid,
    output logic                           d_in_ready,
    input  logic [2:0]                     d_in_opcode,
    input  logic [1:0]                     d_in_param,
    input  logic [SIZE_W-1:0]              d_in_size,
    input  logic [SRC_W-1:0]               d_in_source,
    input  logic                           d_in_sink,
    input  logic                           d_in_denied,
    input  logic [DATA_W-1:0]              d_in_data,
    input  logic                           d_in_corrupt,
    output logic                           d_out_valid,
    input  logic                           d_out_ready,
    output logic [2:0]                     d_out_opcode,
    output logic [1:0]                     d_out_param,
    output logic [SIZE_W-1:0]              d_out_size,
    output logic [SRC_W-1:0]               d_out_source,
    output logic                           d_out_sink,
    output logic                           d_out_denied,
    output logic [DATA_W-1:0]              d_out_data,
    output logic                           d_out_corrupt,
    output logic [$clog2(A_DEPTH+1)-1:0]   a_count,
    output logic [$clog2(D_DEPTH+1)-1:0]   d_count
);
    localparam int unsigned AW = 3 + 3 + SIZE_W + SRC_W + ADDR_W + DATA_W/8 + DATA_W + 1;
    localparam int unsigned DW = 3 + 2 + SIZE_W + SRC_W + 1 + 1 + DATA_W + 1;

    logic [AW-1:0] a_in_bits;
    logic [AW-1:0] a_out_bits;
    logic [DW-1:0] d_in_bits;
    logic [DW-1:0] d_out_bits;

    assign a_in_bits = {a_in_opcode, a_in_param, a_in_size, a_in_source,
                        a_in_address, a_in_mask, a_in_data, a_in_corrupt};
    assign {a_out_opcode, a_out_param, a_out_size, a_out_source,
            a_out_address, a_out_mask, a_out_data, a_out_corrupt} = a_out_bits;

    assign d_in_bits = {d_in_opcode, d_in_param, d_in_size, d_in_source,
                        d_in_sink, d_in_denied, d_in_data, d_in_corrupt};
    assign {d_out_opcode, d_out_param, d_out_size, d_out_source,
            d_out_sink, d_out_denied, d_out_data, d_out_corrupt} = d_out_bits;

    tl_ad_buffer_fifo #(
        .WIDTH (AW),
        .DEPTH (A_DEPTH),
        .FLOW  (A_FLOW != 0),
        .PIPE  (A_PIPE != 0),
        .CW    ($clog2(A_DEPTH + 1))
    ) u_a_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_bits   (a_in_bits),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_bits  (a_out_bits),
        .count     (a_count)
    );

    tl_ad_buffer_fifo #(
        .WIDTH (DW),
        .DEPTH (D_DEPTH),
        .FLOW  (D_FLOW != 0),
        .PIPE  (D_PIPE != 0),
        .CW    ($clog2(D_DEPTH + 1))
    ) u_d_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_bits   (d_in_bits),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_bits  (d_out_bits),
        .count     (d_count)
    );
endmodule

// File: tb/tb_tl_ad_buffer.sv
// Scoreboard bench for tl_ad_buffer: A channel depth 3 with flow, D channel depth 2 with pipe.

module tb_tl_ad_buffer;
    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 32;
    localparam int SRC_W   = 7;
    localparam int SIZE_W  = 4;
    localparam int A_DEPTH = 3;
    localparam int D_DEPTH = 2;
    localparam int ACW     = $clog2(A_DEPTH + 1);
    localparam int DCW     = $clog2(D_DEPTH + 1);

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SRC_W-1:0]    source;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W/8-1:0] mask;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } a_beat_t;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [1:0]        param;
        logic [SIZE_W-1:0] size;
        logic [SRC_W-1:0]  source;
        logic              sink;
        logic              denied;
        logic [DATA_W-1:0] data;
        logic              corrupt;
    } d_beat_t;

    logic clock;
    logic reset;
    logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    a_beat_t a_in, a_out_s;
    d_beat_t d_in, d_out_s;
    logic [2:0]          a_out_opcode, a_out_param;
    logic [SIZE_W-1:0]   a_out_size;
    logic [SRC_W-1:0]    a_out_source;
    logic [ADDR_W-1:0]   a_out_address;
    logic [DATA_W/8-1:0] a_out_mask;
    logic [DATA_W-1:0]   a_out_data;
    logic                a_out_corrupt;
    logic [2:0]          d_out_opcode;
    logic [1:0]          d_out_param;
    logic [SIZE_W-1:0]   d_out_size;
    logic [SRC_W-1:0]    d_out_source;
    logic                d_out_sink, d_out_denied, d_out_corrupt;
    logic [DATA_W-1:0]   d_out_data;
    logic [ACW-1:0]      a_count;
    logic [DCW-1:0]      d_count;

    assign a_out_s = {a_out_opcode, a_out_param, a_out_size, a_out_source,
                      a_out_address, a_out_mask, a_out_data, a_out_corrupt};
    assign d_out_s = {d_out_opcode, d_out_param, d_out_size, d_out_source,
                      d_out_sink, d_out_denied, d_out_data, d_out_corrupt};

    tl_ad_buffer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SRC_W   (SRC_W),
        .SIZE_W  (SIZE_W),
        .A_DEPTH (A_DEPTH),
        .D_DEPTH (D_DEPTH),
        .A_FLOW  (1),
        .D_FLOW  (0),
        .A_PIPE  (0),
        .D_PIPE  (1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .a_in_valid    (a_in_valid),
        .a_in_ready    (a_in_ready),
        .a_in_opcode   (a_in.opcode),
        .a_in_param    (a_in.param),
        .a_in_size     (a_in.size),
        .a_in_source   (a_in.source),
        .a_in_address  (a_in.address),
        .a_in_mask     (a_in.mask),
        .a_in_data     (a_in.data),
        .a_in_corrupt  (a_in.corrupt),
        .a_out_valid   (a_out_valid),
        .a_out_ready   (a_out_ready),
        .a_out_opcode  (a_out_opcode),
        .a_out_param   (a_out_param),
        .a_out_size    (a_out_size),
        .a_out_source  (a_out_source),
        .a_out_address (a_out_address),
        .a_out_mask    (a_out_mask),
        .a_out_data    (a_out_data),
        .a_out_corrupt (a_out_corrupt),
        .d_in_valid    (d_in_valid),
        .d_in_ready    (d_in_ready),
        .d_in_opcode   (d_in.opcode),
        .d_in_param    (d_in.param),
        .d_in_size     (d_in.size),
        .d_in_source   (d_in.source),
        .d_in_sink     (d_in.sink),
        .d_in_denied   (d_in.denied),
        .d_in_data     (d_in.data),
        .d_in_corrupt  (d_in.corrupt),
        .d_out_valid   (d_out_valid),
        .d_out_ready   (d_out_ready),
        .d_out_opcode  (d_out_opcode),
        .d_out_param   (d_out_param),
        .d_out_size    (d_out_size),
        .d_out_source  (d_out_source),
        .d_out_sink    (d_out_sink),
        .d_out_denied  (d_out_denied),
        .d_out_data    (d_out_data),
        .d_out_corrupt (d_out_corrupt),
        .a_count       (a_count),
        .d_count       (d_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    a_beat_t a_sb[$];
    d_beat_t d_sb[$];
    int  a_occ_pre = 0;
    int  d_occ_pre = 0;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic a_beat_t rand_a();
        a_beat_t b;
        b.opcode  = 3'($urandom);
        b.param   = 3'($urandom);
        b.size    = SIZE_W'($urandom);
        b.source  = SRC_W'($urandom);
        b.address = ADDR_W'($urandom);
        b.mask    = (DATA_W/8)'($urandom);
        b.data    = $urandom;
        b.corrupt = 1'($urandom);
        return b;
    endfunction

    function automatic d_beat_t rand_d();
        d_beat_t b;
        b.opcode  = 3'($urandom);
        b.param   = 2'($urandom);
        b.size    = SIZE_W'($urandom);
        b.source  = SRC_W'($urandom);
        b.sink    = 1'($urandom);
        b.denied  = 1'($urandom);
        b.data    = $urandom;
        b.corrupt = 1'($urandom);
        return b;
    endfunction

    // Reference model: a beat is accepted when the buffer has room (A) or has room or
    // is being drained (D); every accepted beat must later appear in order, unmodified.
    task automatic cycle(input logic av, input a_beat_t ab, input logic ar,
                         input logic dv, input d_beat_t db, input logic dr,
                         output logic a_acc, output logic d_acc);
        @(posedge clock);
        #1;
        a_in_valid  = av;
        a_in        = ab;
        a_out_ready = ar;
        d_in_valid  = dv;
        d_in        = db;
        d_out_ready = dr;
        a_occ_pre   = a_sb.size();
        d_occ_pre   = d_sb.size();
        a_acc = av && (a_occ_pre < A_DEPTH);
        d_acc = dv && ((d_occ_pre < D_DEPTH) || dr);
        if (a_acc) a_sb.push_back(ab);
        if (d_acc) d_sb.push_back(db);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            check("a_in_ready",  128'(a_in_ready),  128'(a_occ_pre < A_DEPTH));
            check("a_out_valid", 128'(a_out_valid), 128'((a_occ_pre > 0) || a_in_valid));
            check("a_count",     128'(a_count),     128'(a_occ_pre));
            check("d_in_ready",  128'(d_in_ready),  128'((d_occ_pre < D_DEPTH) || d_out_ready));
            check("d_out_valid", 128'(d_out_valid), 128'(d_occ_pre > 0));
            check("d_count",     128'(d_count),     128'(d_occ_pre));
            if (a_out_valid && a_out_ready) begin
                if (a_sb.size() == 0) check("a_unexpected_beat", 128'(1), 128'(0));
                else check("a_beat", 128'(a_out_s), 128'(a_sb.pop_front()));
            end
            if (d_out_valid && d_out_ready) begin
                if (d_sb.size() == 0) check("d_unexpected_beat", 128'(1), 128'(0));
                else check("d_beat", 128'(d_out_s), 128'(d_sb.pop_front()));
            end
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #1;
        mon_en = 1'b0;
        reset = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        d_in_valid = 1'b0; d_out_ready = 1'b0;
        a_sb.delete();
        d_sb.delete();
        @(negedge clock);
        check("rst0_a_in_ready",  128'(a_in_ready),  128'(0));
        check("rst0_d_in_ready",  128'(d_in_ready),  128'(0));
        check("rst0_a_out_valid", 128'(a_out_valid), 128'(0));
        check("rst0_d_out_valid", 128'(d_out_valid), 128'(0));
        @(posedge clock);
        #1;
        @(negedge clock);
        check("rst1_a_in_ready",  128'(a_in_ready),  128'(0));
        check("rst1_d_in_ready",  128'(d_in_ready),  128'(0));
        check("rst1_a_out_valid", 128'(a_out_valid), 128'(0));
        check("rst1_d_out_valid", 128'(d_out_valid), 128'(0));
        check("rst1_a_count",     128'(a_count),     128'(0));
        check("rst1_d_count",     128'(d_count),     128'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        a_occ_pre = 0;
        d_occ_pre = 0;
        mon_en = 1'b1;
    endtask

    task automatic drain();
        logic aa, da;
        for (int n = 0; n < 20 && (a_sb.size() != 0 || d_sb.size() != 0); n++)
            cycle(1'b0, rand_a(), 1'b1, 1'b0, rand_d(), 1'b1, aa, da);
        check("drain_a_empty", 128'(a_sb.size()), 128'(0));
        check("drain_d_empty", 128'(d_sb.size()), 128'(0));
    endtask

    initial begin
        logic        aa, da;
        a_beat_t     ab;
        d_beat_t     db;
        int          sent;
        logic [13:0] addrs [3];

        reset = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_in = '0;
        d_in_valid = 1'b0; d_out_ready = 1'b0; d_in = '0;
        do_reset();

        // Fill A to depth 3 with ready low, attempt a fourth, then drain in order.
        addrs[0] = 14'h10; addrs[1] = 14'h20; addrs[2] = 14'h30;
        for (int i = 0; i < 3; i++) begin
            ab = rand_a();
            ab.address = addrs[i];
            cycle(1'b1, ab, 1'b0, 1'b0, rand_d(), 1'b0, aa, da);
        end
        cycle(1'b1, rand_a(), 1'b0, 1'b0, rand_d(), 1'b0, aa, da);
        cycle(1'b0, rand_a(), 1'b0, 1'b0, rand_d(), 1'b0, aa, da);
        drain();

        // Flow-through on an empty A FIFO.
        ab = rand_a();
        ab.source = 7'h5A;
        cycle(1'b1, ab, 1'b1, 1'b0, rand_d(), 1'b0, aa, da);
        cycle(1'b0, rand_a(), 1'b1, 1'b0, rand_d(), 1'b0, aa, da);

        // D wrap-around: data 0..9 under random backpressure.
        sent = 0;
        for (int n = 0; n < 200 && sent < 10; n++) begin
            db = rand_d();
            db.data = DATA_W'(sent);
            cycle(1'b0, rand_a(), 1'b0, 1'b1, db, 1'($urandom_range(0, 1)), aa, da);
            if (da) sent++;
        end
        drain();

        // D pipe: fill to 2, then one in and one out per cycle.
        for (int i = 0; i < 2; i++) cycle(1'b0, rand_a(), 1'b0, 1'b1, rand_d(), 1'b0, aa, da);
        for (int i = 0; i < 4; i++) cycle(1'b0, rand_a(), 1'b0, 1'b1, rand_d(), 1'b1, aa, da);
        drain();

        // Channel independence: D parked full while A streams 8 beats.
        for (int i = 0; i < 2; i++) cycle(1'b0, rand_a(), 1'b0, 1'b1, rand_d(), 1'b0, aa, da);
        cycle(1'b1, rand_a(), 1'b0, 1'b0, rand_d(), 1'b0, aa, da);
        for (int i = 0; i < 8; i++) cycle(1'b1, rand_a(), 1'b1, 1'b0, rand_d(), 1'b0, aa, da);
        drain();

        // Mid-stream reset with two A beats held; the next beat out must be the new one.
        for (int i = 0; i < 2; i++) cycle(1'b1, rand_a(), 1'b0, 1'b1, rand_d(), 1'b0, aa, da);
        cycle(1'b0, rand_a(), 1'b0, 1'b0, rand_d(), 1'b0, aa, da);
        do_reset();
        cycle(1'b1, rand_a(), 1'b0, 1'b1, rand_d(), 1'b0, aa, da);
        drain();

        // Random traffic on both channels.
        for (int n = 0; n < 400; n++)
            cycle(1'($urandom_range(0, 3) != 0), rand_a(), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 3) != 0), rand_d(), 1'($urandom_range(0, 2) != 0),
                  aa, da);
        drain();

        @(posedge clock);
        #1;
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
